// File: rtl/router_src_modport_if.sv
// router_src_modport_if: source-side byte bus plus downstream valid/ready port.
// The master modport is the agent's view; slave is the router block's view.
interface router_src_modport_if;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       busy;
    logic       err;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_last;
    modport master (
        output data_in, pkt_valid, dout_ready,
        input  busy, err, dout, dout_valid, dout_last
    );
    modport slave (
        input  data_in, pkt_valid, dout_ready,
        output busy, err, dout, dout_valid, dout_last
    );
endinterface

// File: rtl/router_src_modport.sv
// router_src_modport: packet ingress with parity check, byte FIFO and valid/ready egress.
// Define PKT_STATS_EN to add saturating good/bad packet counters.
module router_src_modport #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W = 8
) (
    input logic clock,
    input logic resetn,
    router_src_modport_if.slave bus
`ifdef PKT_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] IDLE = 2'd0, PAYLOAD = 2'd1, PARITY = 2'd2;
    logic [1:0] state;
    logic [DATA_W-3:0] remaining;
    logic [DATA_W-1:0] parity;
    logic [DATA_W:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic accept, push, pop, last_flag, err_q;
    assign bus.busy = count == CW'(FIFO_DEPTH);
    assign bus.dout_valid = count != '0;
    assign {bus.dout_last, bus.dout} = mem[rd_ptr];
    assign bus.err = err_q;
    assign accept = bus.pkt_valid & ~bus.busy;
    assign push = accept & (state != PARITY);
    assign pop = bus.dout_valid & bus.dout_ready;
    // A zero-length header is itself the last forwarded byte
    assign last_flag = (state == IDLE) ? (bus.data_in[DATA_W-1:2] == '0) : (remaining == 1);
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= {last_flag, bus.data_in};
    always_ff @(posedge clock) begin
        if (resetn) begin
            state <= IDLE;
            remaining <= '0;
            parity <= '0;
            err_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (accept)
                case (state)
                    IDLE: begin
                        parity <= bus.data_in;
                        remaining <= bus.data_in[DATA_W-1:2];
                        state <= (bus.data_in[DATA_W-1:2] == '0) ? PARITY : PAYLOAD;
                    end
                    PAYLOAD: begin
                        parity <= parity ^ bus.data_in;
                        remaining <= remaining - 1'b1;
                        state <= (remaining == 1) ? PARITY : PAYLOAD;
                    end
                    default: begin
                        err_q <= bus.data_in != parity;
                        state <= IDLE;
                    end
                endcase
        end
    end
`ifdef PKT_STATS_EN
    logic parity_acc;
    assign parity_acc = accept & (state != IDLE) & (state != PAYLOAD);
    always_ff @(posedge clock) begin
        if (resetn) begin
            good_cnt <= '0;
            bad_cnt <= '0;
        end else if (parity_acc) begin
            if (bus.data_in == parity)
                good_cnt <= (good_cnt == 16'hFFFF) ? good_cnt : good_cnt + 16'd1;
            else
                bad_cnt <= (bad_cnt == 16'hFFFF) ? bad_cnt : bad_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_router_src_modport.sv
// tb_router_src_modport: directed packets checked every cycle against a packet-level queue model.
module tb_router_src_modport;
    localparam int DEPTH = 16;
    logic clock = 1'b0;
    logic resetn;
    int checks = 0;
    int failures = 0;
    router_src_modport_if bus();
`ifdef PKT_STATS_EN
    logic [15:0] good_cnt, bad_cnt;
`endif
    router_src_modport #(.FIFO_DEPTH(DEPTH)) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(bus)
`ifdef PKT_STATS_EN
        ,
        .good_cnt(good_cnt),
        .bad_cnt(bad_cnt)
`endif
    );
    always #5 clock = ~clock;

    // Model: expected output queue, position within the current packet, parity sum
    logic [8:0] q[$];
    logic [8:0] log_q[$];
    int k = 0;
    int mlen = 0;
    logic [7:0] msum = '0;
    logic m_err = 1'b0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        if (resetn) begin
            q.delete();
            k = 0;
            m_err = 1'b0;
            started = 1'b1;
        end else if (started) begin
            bit acc;
            acc = bus.pkt_valid && (q.size() < DEPTH);
            if (q.size() != 0 && bus.dout_ready) void'(q.pop_front());
            if (acc) begin
                if (k == 0) begin
                    mlen = int'(bus.data_in) / 4;
                    msum = bus.data_in;
                    q.push_back({mlen == 0, bus.data_in});
                    k = 1;
                end else if (k <= mlen) begin
                    msum = msum ^ bus.data_in;
                    q.push_back({k == mlen, bus.data_in});
                    k++;
                end else begin
                    m_err = bus.data_in != msum;
                    k = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("busy", bus.busy, q.size() == DEPTH);
            chk("dout_valid", bus.dout_valid, q.size() != 0);
            chk("err", bus.err, m_err);
            if (q.size() != 0) begin
                chk("dout", bus.dout, q[0][7:0]);
                chk("dout_last", bus.dout_last, q[0][8]);
            end
        end
    end

    // Record what the DUT actually hands downstream, sampled just before each rising edge
    always @(negedge clock) begin
        #4;
        if (started && !resetn && bus.dout_valid && bus.dout_ready)
            log_q.push_back({bus.dout_last, bus.dout});
    end

    task automatic wait_slot();
        @(negedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) wait_slot();
    endtask

    task automatic hold_until_taken();
        int t = 0;
        while (bus.busy && t < 500) begin
            wait_slot();
            t++;
        end
        if (bus.busy) chk("send_timeout", 1, 0);
        wait_slot();
        bus.pkt_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bus.data_in = b;
        bus.pkt_valid = 1'b1;
        hold_until_taken();
    endtask

    task automatic chk_log(input int idx, input logic [8:0] exp);
        chk($sformatf("log[%0d]", idx), (idx < log_q.size()) ? log_q[idx] : 9'h1FF, exp);
    endtask

    initial begin
        logic [7:0] b, par;
        int n0;
        resetn = 1'b1;
        bus.pkt_valid = 1'b1;
        bus.data_in = 8'h55;
        bus.dout_ready = 1'b0;
        idle(2);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_valid", bus.dout_valid, 0);
        resetn = 1'b0;
        bus.pkt_valid = 1'b0;
        bus.dout_ready = 1'b1;
        idle(2);
        chk("rst_nothing_written", bus.dout_valid, 0);

        // Good packet
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h0D);
        idle(3);
        chk("good_err", bus.err, 0);
        chk("good_count", log_q.size(), 4);
        chk_log(0, 9'h00D); chk_log(1, 9'h011); chk_log(2, 9'h022); chk_log(3, 9'h133);

        // Bad parity still forwards, then a good packet clears err
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
        idle(3);
        chk("bad_err", bus.err, 1);
        chk_log(4, 9'h00D); chk_log(7, 9'h133);
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h0D);
        idle(3);
        chk("clear_err", bus.err, 0);
        chk("after3_count", log_q.size(), 12);

        // Backpressure with a 63-byte payload
        bus.dout_ready = 1'b0;
        par = 8'hFC;
        send(8'hFC);
        for (int i = 0; i < 15; i++) begin
            b = 8'(i * 3 + 1);
            par ^= b;
            send(b);
        end
        n0 = log_q.size();
        b = 8'(15 * 3 + 1);
        par ^= b;
        bus.data_in = b;
        bus.pkt_valid = 1'b1;
        idle(3);
        chk("bp_busy", bus.busy, 1);
        chk("bp_no_output", log_q.size(), n0);
        bus.dout_ready = 1'b1;
        hold_until_taken();
        for (int i = 16; i < 63; i++) begin
            b = 8'(i * 3 + 1);
            par ^= b;
            send(b);
        end
        send(par);
        idle(70);
        chk("bp_count", log_q.size(), 76);
        chk("bp_err", bus.err, 0);
        chk_log(12, 9'h0FC);
        chk_log(13, 9'h001);
        chk_log(75, {1'b1, 8'(62 * 3 + 1)});

        // Zero-length packet with gaps, then a bad zero-length packet
        send(8'h02);
        idle(2);
        send(8'h02);
        idle(3);
        chk("zl_err", bus.err, 0);
        chk_log(76, 9'h102);
        send(8'h02);
        send(8'hFF);
        idle(3);
        chk("zl_bad_err", bus.err, 1);
        chk_log(77, 9'h102);

        // Reset mid-packet
        bus.dout_ready = 1'b0;
        send(8'h0D); send(8'h11); send(8'h22);
        chk("mid_valid", bus.dout_valid, 1);
        resetn = 1'b1;
        wait_slot();
        resetn = 1'b0;
        chk("mid_rst_valid", bus.dout_valid, 0);
        chk("mid_rst_err", bus.err, 0);
        chk("mid_rst_busy", bus.busy, 0);
        bus.dout_ready = 1'b1;
        send(8'h09); send(8'hAA); send(8'hBB); send(8'h18);
        idle(4);
        chk("post_rst_err", bus.err, 0);
        chk("post_rst_count", log_q.size(), 81);
        chk_log(78, 9'h009); chk_log(79, 9'h0AA); chk_log(80, 9'h1BB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
